// File: rtl/basic_gates.sv
// basic_gates: registered bitwise AND/OR/XOR/NOT/NAND of two operands.
// Define BASIC_GATES_EXT_EN to add registered NOR (h) and XNOR (i) outputs.
module basic_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
`ifdef BASIC_GATES_EXT_EN
  output logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] i,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             vld_q, vld_d;
`ifdef BASIC_GATES_EXT_EN
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] i_q, i_d;
`endif

  // Next state: load gate results when enabled, otherwise hold.
  always_comb begin
    c_d   = c_q;
    d_d   = d_q;
    e_d   = e_q;
    f_d   = f_q;
    g_d   = g_q;
    vld_d = en;
`ifdef BASIC_GATES_EXT_EN
    h_d   = h_q;
    i_d   = i_q;
`endif
    if (en) begin
      c_d = a & b;
      d_d = a | b;
      e_d = a ^ b;
      f_d = ~a;
      g_d = ~(a & b);
`ifdef BASIC_GATES_EXT_EN
      h_d = ~(a | b);
      i_d = ~(a ^ b);
`endif
    end
  end

  // Result flops; reset forces constant zeros and wins over en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q   <= '0;
      d_q   <= '0;
      e_q   <= '0;
      f_q   <= '0;
      g_q   <= '0;
      vld_q <= 1'b0;
`ifdef BASIC_GATES_EXT_EN
      h_q   <= '0;
      i_q   <= '0;
`endif
    end else begin
      c_q   <= c_d;
      d_q   <= d_d;
      e_q   <= e_d;
      f_q   <= f_d;
      g_q   <= g_d;
      vld_q <= vld_d;
`ifdef BASIC_GATES_EXT_EN
      h_q   <= h_d;
      i_q   <= i_d;
`endif
    end
  end

  assign c         = c_q;
  assign d         = d_q;
  assign e         = e_q;
  assign f         = f_q;
  assign g         = g_q;
  assign out_valid = vld_q;
`ifdef BASIC_GATES_EXT_EN
  assign h         = h_q;
  assign i         = i_q;
`endif

endmodule

// File: tb/tb_basic_gates.sv
// tb_basic_gates: directed vectors with a queue-based scoreboard.
// Stimulus pushes hand-computed expectations; a monitor pops per edge.
module tb_basic_gates;

  localparam int W = 4;

  typedef struct {
    logic         v;
    logic [W-1:0] c, d, e, f, g, h, i;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] a, b;
  logic [W-1:0] c, d, e, f, g;
  logic         out_valid;
`ifdef BASIC_GATES_EXT_EN
  logic [W-1:0] h, i;
`endif

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  basic_gates #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
`ifdef BASIC_GATES_EXT_EN
    .h         (h),
    .i         (i),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, compared after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, x.v});
      chk("c", c, x.c);
      chk("d", d, x.d);
      chk("e", e, x.e);
      chk("f", f, x.f);
      chk("g", g, x.g);
`ifdef BASIC_GATES_EXT_EN
      chk("h", h, x.h);
      chk("i", i, x.i);
`endif
    end
  end

  // Drive one edge's inputs; a glitch value precedes the settled one.
  task automatic step(input logic r, input logic en_v,
                      input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic v, input logic [W-1:0] ec,
                      input logic [W-1:0] ed, input logic [W-1:0] ee,
                      input logic [W-1:0] ef, input logic [W-1:0] eg,
                      input logic [W-1:0] eh, input logic [W-1:0] ei);
    exp_t x;
    @(negedge clk);
    a = ~av;
    b = ~bv;
    #2;
    rst_n = r;
    en    = en_v;
    a     = av;
    b     = bv;
    x.v = v; x.c = ec; x.d = ed; x.e = ee;
    x.f = ef; x.g = eg; x.h = eh; x.i = ei;
    q.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    a     = '1;
    b     = '1;
    // reset held two cycles with a=b=1 and en=1
    step(0, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // truth table rows, replicated across all bits
    step(1, 1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    step(1, 1, 4'h0, 4'hF, 1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0);
    step(1, 1, 4'hF, 4'h0, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
    step(1, 1, 4'hF, 4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    // en low: hold last result, valid drops
    step(1, 0, 4'h0, 4'h0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    step(1, 0, 4'h5, 4'h3, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    // multi-bit independence
    step(1, 1, 4'hC, 4'hA, 1, 4'h8, 4'hE, 4'h6, 4'h3, 4'h7, 4'h1, 4'h9);
    // reset wins over en on the same edge
    step(0, 1, 4'h1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(1, 0, 4'h1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // first capture after reset
    step(1, 1, 4'h3, 4'h5, 1, 4'h1, 4'h7, 4'h6, 4'hC, 4'hE, 4'h8, 4'h9);
    step(1, 1, 4'h0, 4'h5, 1, 4'h0, 4'h5, 4'h5, 4'hF, 4'hF, 4'hA, 4'hA);
    step(1, 0, 4'hF, 4'hF, 0, 4'h0, 4'h5, 4'h5, 4'hF, 4'hF, 4'hA, 4'hA);
    // drain scoreboard with a bound
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_gates.md
BASIC_GATES -- requirements
Module: basic_gates

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of operands and of every gate result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low, sampled on rising clk.
REQ-004 Port: en  input  1  capture enable; result registers update only when high.
REQ-005 Port: a  input  WIDTH  operand A.
REQ-006 Port: b  input  WIDTH  operand B.
REQ-007 Port: c  output  WIDTH  registered bitwise AND, a & b.
REQ-008 Port: d  output  WIDTH  registered bitwise OR, a | b.
REQ-009 Port: e  output  WIDTH  registered bitwise XOR, a ^ b.
REQ-010 Port: f  output  WIDTH  registered bitwise NOT of a only; b is ignored.
REQ-011 Port: g  output  WIDTH  registered bitwise NAND, ~(a & b).
REQ-012 Port: out_valid  output  1  high for each cycle in which c..g hold a result captured from en=1.

Function
REQ-013 All gate functions SHALL be bitwise, per bit index, with no carries or cross-bit interaction.
REQ-014 On a rising clk edge with rst_n=1 and en=1, c, d, e, f and g SHALL load the functions of the a and b values sampled at that edge; latency is exactly 1 cycle.
REQ-015 On a rising clk edge with rst_n=1 and en=0, c..g SHALL hold their previous values.
REQ-016 out_valid SHALL be registered: it is set to 1 on an edge with en=1 and cleared to 0 on an edge with en=0.
REQ-017 Outputs SHALL be driven only from flops, with no combinational path from a, b or en to any output.
REQ-018 When a and b change between edges, only the values present at the sampling edge SHALL affect the outputs; glitches between edges SHALL be ignored.
REQ-019 Truth table per bit (a,b -> c,d,e,f,g):
- 00 -> 0,0,0,1,1
- 01 -> 0,1,1,1,1
- 10 -> 0,1,1,0,1
- 11 -> 1,1,0,0,0

Reset
REQ-020 On a rising clk edge with rst_n=0, the block SHALL force c=0, d=0, e=0, f=0, g=0 and out_valid=0, regardless of en, a and b.
- These reset values are fixed constants; they are not gate results of zero inputs.
REQ-021 Reset SHALL take priority over en.
REQ-022 Asserting reset mid-operation SHALL discard the pending result on that same edge.
REQ-023 The first capture after reset SHALL occur on the first edge with rst_n=1 and en=1.

Configuration
REQ-024 With macro BASIC_GATES_EXT_EN defined, the block SHALL add two registered outputs, both width WIDTH and both obeying REQ-014..REQ-023:
- h: bitwise NOR, ~(a | b).
- i: bitwise XNOR, ~(a ^ b).
REQ-025 Without BASIC_GATES_EXT_EN, ports h and i SHALL NOT exist, and the behaviour of all other ports SHALL be identical.

Verification
REQ-026 rst_n=0 for 2 cycles, with a=1 and b=1 -> c..g=0 and out_valid=0 throughout reset.
REQ-027 With WIDTH=1, en=1, step {a,b} through 00, 01, 10, 11 on successive cycles -> one cycle later, {c,d,e,f,g} = 00011, 01111, 01101, 11000, in that order.
REQ-028 Load a=1, b=1, then drop en and change to a=0, b=0 -> c..g hold 1,1,0,0,0 and out_valid=0.
REQ-029 With WIDTH=4, a=4'b1100, b=4'b1010 -> c=1000, d=1110, e=0110, f=0011, g=0111.
REQ-030 Assert rst_n=0 on the same edge as en=1 with a=1, b=0 -> all outputs 0 after that edge.
REQ-031 With BASIC_GATES_EXT_EN defined and WIDTH=1, a=0, b=1 -> h=0 and i=0 one cycle later; with a=1, b=1 -> h=0 and i=1.
